// File: rtl/stopwatch_digit_source.sv
// Prescaled BCD stopwatch (SS.hh) feeding four per-digit hex decoders.
// Optional macro LEADING_ZERO_BLANK_EN blanks the seconds-tens digit while it is zero.
module stopwatch_digit_source #(
  parameter int TICK_DIV = 500000,
  parameter int PRE_W    = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startstop,
  input  logic        lap,
  input  logic        clear,
  output logic [15:0] val,
  output logic [3:0]  noDecimal,
  output logic [7:0]  enable,
  output logic        running,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t            state;
  logic [PRE_W-1:0]  pre;
  logic [15:0]       count;
  logic [15:0]       count_inc;
  logic              carry;
  logic              counting;
  logic              tick;
  logic              wrap;

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (pre == PRE_LAST);
  assign wrap     = (count == 16'h9999);

  // Ripple the increment through the four BCD digits in a single cycle.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pre     <= '0;
      count   <= 16'h0000;
      ovf     <= 1'b0;
      val     <= 16'h0000;
      running <= 1'b0;
    end else begin
      // In LAP the display keeps the snapshot taken on the entering edge.
      if (state != LAP) val <= count;

      if (clear) begin
        state   <= IDLE;
        pre     <= '0;
        count   <= 16'h0000;
        ovf     <= 1'b0;
        running <= 1'b0;
      end else begin
        if (counting) pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          count <= count_inc;
          if (wrap) ovf <= 1'b1;
        end

        // startstop outranks lap; a tick in the same cycle is already applied above.
        case (state)
          IDLE: begin
            if (startstop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (startstop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (lap) begin
              state <= LAP;
            end
          end
          LAP: begin
            if (startstop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (lap) begin
              state <= RUN;
            end
          end
          PAUSE: begin
            if (startstop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  // Decimal point sits after the seconds-units digit (index 2).
  assign noDecimal = 4'b1011;

`ifdef LEADING_ZERO_BLANK_EN
  assign enable = {((val[15:12] == 4'd0) ? 2'd0 : 2'd1), 6'b01_01_01};
`else
  assign enable = 8'h55;
`endif

endmodule

// File: tb/tb_stopwatch_digit_source.sv
// Bench for stopwatch_digit_source: directed scenarios plus random pulses, checked
// every cycle against a centisecond-integer model of the stopwatch.
module tb_stopwatch_digit_source;

  localparam int TICK_DIV = 4;
  localparam int W = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startstop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] val;
  logic [3:0]  noDecimal;
  logic [7:0]  enable;
  logic        running;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  stopwatch_digit_source #(.TICK_DIV(TICK_DIV), .PRE_W(3)) dut (
    .clk(clk), .reset(reset), .startstop(startstop), .lap(lap), .clear(clear),
    .val(val), .noDecimal(noDecimal), .enable(enable), .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
  int   m_state;
  int   m_cs;       // elapsed time in centiseconds, 0..9999
  int   m_pre;
  int   m_shown;    // centiseconds currently on the display
  bit   m_ovf;
  bit   m_run;
  bit   model_ok = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int cs);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(cs / 1000);
    d2 = 4'((cs / 100) % 10);
    d1 = 4'((cs / 10) % 10);
    d0 = 4'(cs % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [7:0] exp_enable(input int shown);
`ifdef LEADING_ZERO_BLANK_EN
    return (shown / 1000 == 0) ? 8'h15 : 8'h55;
`else
    return (shown >= 0) ? 8'h55 : 8'h55;
`endif
  endfunction

  always @(posedge clk) begin
    int  next_shown;
    bit  tick;
    if (reset) begin
      m_state = M_IDLE; m_cs = 0; m_pre = 0; m_ovf = 0; m_shown = 0; m_run = 0;
      model_ok = 1;
    end else if (model_ok) begin
      next_shown = (m_state == M_LAP) ? m_shown : m_cs;
      tick = (m_state == M_RUN || m_state == M_LAP) && (m_pre == TICK_DIV - 1);
      if (clear) begin
        m_state = M_IDLE; m_cs = 0; m_pre = 0; m_ovf = 0;
      end else begin
        if (m_state == M_RUN || m_state == M_LAP) m_pre = tick ? 0 : m_pre + 1;
        if (tick) begin
          m_cs = (m_cs + 1) % 10000;
          if (m_cs == 0) m_ovf = 1;
        end
        if (startstop) begin
          m_state = (m_state == M_RUN || m_state == M_LAP) ? M_PAUSE : M_RUN;
        end else if (lap) begin
          if (m_state == M_RUN) m_state = M_LAP;
          else if (m_state == M_LAP) m_state = M_RUN;
        end
      end
      m_shown = next_shown;
      m_run = (m_state == M_RUN || m_state == M_LAP);
    end
    if (model_ok)
      exp_q.push_back({to_bcd(m_shown), 4'b1011, exp_enable(m_shown), m_run, m_ovf});
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cyc_val",       val,               e[29:14]);
      check("cyc_noDecimal", {12'd0, noDecimal}, {12'd0, e[13:10]});
      check("cyc_enable",    {8'd0, enable},    {8'd0, e[9:2]});
      check("cyc_running",   {15'd0, running},  {15'd0, e[1]});
      check("cyc_ovf",       {15'd0, ovf},      {15'd0, e[0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bit 2 = clear, bit 1 = startstop, bit 0 = lap; held for one sampling edge
  task automatic pulse(input logic [2:0] which);
    clear = which[2]; startstop = which[1]; lap = which[0];
    cycles(1);
    clear = 1'b0; startstop = 1'b0; lap = 1'b0;
  endtask

  localparam logic [2:0] P_CLR = 3'b100, P_SS = 3'b010, P_LAP = 3'b001;
  localparam logic [7:0] EN_LOW = 8'h55;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] EN_SUB10 = 8'h15;
`else
  localparam logic [7:0] EN_SUB10 = 8'h55;
`endif

  initial begin
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    check("rst_val", val, 16'h0000);
    check("rst_nodec", {12'd0, noDecimal}, 16'h000B);
    check("rst_enable", {8'd0, enable}, {8'd0, EN_SUB10});
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_ovf", {15'd0, ovf}, 16'd0);
    cycles(20);
    check("idle_val", val, 16'h0000);

    // 10 ticks after start, display follows one cycle later
    pulse(P_SS);
    cycles(40);
    check("run_val_9", val, 16'h0009);
    cycles(1);
    check("run_val_10", val, 16'h0010);
    check("run_running", {15'd0, running}, 16'd1);

    // lap freeze at 00.05
    pulse(P_CLR);
    pulse(P_SS);
    cycles(20);
    pulse(P_LAP);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("lap_frozen", val, 16'h0005);
    end
    pulse(P_LAP);
    cycles(1);
    check("lap_release", val, 16'h0010);

    // run to the wrap
    pulse(P_CLR);
    pulse(P_SS);
    cycles(3997);
    check("val_0999", val, 16'h0999);
    check("en_0999", {8'd0, enable}, {8'd0, EN_SUB10});
    cycles(4);
    check("val_1000", val, 16'h1000);
    check("en_1000", {8'd0, enable}, {8'd0, EN_LOW});
    cycles(35996);
    check("val_9999", val, 16'h9999);
    check("ovf_before", {15'd0, ovf}, 16'd0);
    cycles(4);
    check("wrap_val", val, 16'h0000);
    check("wrap_ovf", {15'd0, ovf}, 16'd1);
    pulse(P_CLR);
    check("clr_ovf", {15'd0, ovf}, 16'd0);
    check("clr_running", {15'd0, running}, 16'd0);

    // pause with prescaler at 2, resume ticks two cycles later
    pulse(P_SS);
    cycles(1);
    pulse(P_SS);
    cycles(50);
    check("pause_val", val, 16'h0000);
    check("pause_running", {15'd0, running}, 16'd0);
    pulse(P_SS);
    cycles(2);
    check("resume_val_0", val, 16'h0000);
    cycles(1);
    check("resume_val_1", val, 16'h0001);

    // clear outranks startstop
    pulse(P_CLR | P_SS);
    check("clr_ss_running", {15'd0, running}, 16'd0);
    cycles(11);
    check("clr_ss_val", val, 16'h0000);

    // random pulses, checked by the per-cycle scoreboard
    for (int i = 0; i < 4000; i++) begin
      startstop = ($urandom_range(0, 11) == 0);
      lap       = ($urandom_range(0, 7) == 0);
      clear     = ($urandom_range(0, 149) == 0);
      reset     = ($urandom_range(0, 599) == 0);
      cycles(1);
    end
    reset = 1'b0; startstop = 1'b0; lap = 1'b0; clear = 1'b0;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
